// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM memory-stage controller: state encoding,
// SRAM bus widths and the default per-phase wait count.
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    ACC_HI = 3'd2,
    DONE   = 3'd3,
    HIT    = 3'd4
  } state_t;

  localparam int unsigned SRAM_ADDR_W     = 18;
  localparam int unsigned SRAM_DATA_W     = 16;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam int unsigned WAIT_CNT_W      = 4;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// SRAM-side bus of the memory controller; master = controller, slave = SRAM.
interface sram_mem_ctrl_if;
  import sram_pkg::*;

  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [SRAM_DATA_W-1:0] sram_dq_out;
  logic [SRAM_DATA_W-1:0] sram_dq_in;
  logic                   sram_dq_oe;
  logic                   sram_we_n;

  modport master (
    output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
    output sram_dq_in
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Down-counter sequencing each SRAM access phase; tc flags the last cycle.
module sram_wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// 32-bit load/store controller over a 16-bit SRAM, two halfword phases per access.
// Optional one-entry read buffer enabled by defining SRAM_RD_BUF_EN.
module sram_mem_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              freeze,
  sram_mem_ctrl_if.master   sram
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t      state;
  logic        is_wr;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [15:0] lo_q;
  logic        req_any;
  logic        hit;
  logic        cnt_load;
  logic        cnt_en;
  logic        cnt_tc;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:19], addr[1:0]};
  assign req_any = MEM_R_EN | MEM_W_EN;
  assign freeze  = req_any & ~ready;

  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      IDLE:    cnt_load = req_any & ~hit;
      ACC_LO:  begin cnt_en = 1'b1; cnt_load = cnt_tc; end
      ACC_HI:  cnt_en = 1'b1;
      default: ;
    endcase
  end

  sram_wait_counter #(.WIDTH(WAIT_CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .enable   (cnt_en),
    .load_val (WAIT_LOAD),
    .tc       (cnt_tc)
  );

`ifdef SRAM_RD_BUF_EN
  logic [16:0] buf_addr;
  logic [31:0] buf_data;
  logic        buf_valid;

  assign hit = MEM_R_EN & ~MEM_W_EN & buf_valid & (buf_addr == addr[18:2]);

  // Invalidate on write acceptance; refill from the same word the read returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
    end else if (state == IDLE && MEM_W_EN && buf_addr == addr[18:2]) begin
      buf_valid <= 1'b0;
    end else if (state == ACC_HI && cnt_tc && !is_wr) begin
      buf_addr  <= word_q;
      buf_data  <= {sram.sram_dq_in, lo_q};
      buf_valid <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      ready            <= 1'b0;
      rdata            <= '0;
      is_wr            <= 1'b0;
      word_q           <= '0;
      wdata_q          <= '0;
      lo_q             <= '0;
      sram.sram_addr   <= '0;
      sram.sram_dq_out <= '0;
      sram.sram_dq_oe  <= 1'b0;
      sram.sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
`ifdef SRAM_RD_BUF_EN
          if (hit) begin
            state <= HIT;
            ready <= 1'b1;
            rdata <= buf_data;
          end else
`endif
          if (req_any) begin
            state          <= ACC_LO;
            is_wr          <= MEM_W_EN;
            word_q         <= addr[18:2];
            wdata_q        <= wdata;
            sram.sram_addr <= {addr[18:2], 1'b0};
            if (MEM_W_EN) begin
              sram.sram_dq_out <= wdata[15:0];
              sram.sram_dq_oe  <= 1'b1;
              sram.sram_we_n   <= 1'b0;
            end
          end
        end
        ACC_LO: begin
          if (cnt_tc) begin
            state          <= ACC_HI;
            sram.sram_addr <= {word_q, 1'b1};
            if (is_wr) sram.sram_dq_out <= wdata_q[31:16];
            else       lo_q             <= sram.sram_dq_in;
          end
        end
        ACC_HI: begin
          if (cnt_tc) begin
            state           <= DONE;
            ready           <= 1'b1;
            sram.sram_dq_oe <= 1'b0;
            sram.sram_we_n  <= 1'b1;
            // rdata updates as a whole word so it holds until the read completes
            if (!is_wr) rdata <= {sram.sram_dq_in, lo_q};
          end
        end
        DONE, HIT: begin
          state <= IDLE;
          ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
